pipe_rate_change_ctrl: RTL and testbench

Sequences a PIPE data-rate/width change for the lane datapath. On a request from LTSSM (Recovery.Speed) it quiesces the datapath, drives the new PIPE Rate/Width to the PHY and waits for the PhyStatus acknowledgement. It then commits the new generation code to the gen decoder and re-enables traffic. It sits between the LTSSM and the gen decoder / PIPE interface and owns the gen, rate and width registers.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_cycle_timer.sv | 17 +
 rtl/pipe_rate_change_ctrl.sv | 137 +++++++++++++
 tb/tb_pipe_rate_change_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared generation codes, PIPE width encodings, FSM states and width helpers
package pipe_pkg;
  localparam logic [2:0] GEN1 = 3'd1;
  localparam logic [2:0] GEN2 = 3'd2;
  localparam logic [2:0] GEN3 = 3'd3;
  localparam logic [2:0] GEN4 = 3'd4;
  localparam logic [2:0] GEN5 = 3'd5;
  localparam logic [1:0] PIPE_WIDTH_8  = 2'd0;
  localparam logic [1:0] PIPE_WIDTH_16 = 2'd1;
  localparam logic [1:0] PIPE_WIDTH_32 = 2'd2;
  typedef enum logic [1:0] {IDLE, DRAIN, RATE_WAIT, SETTLE} state_e;
  function automatic logic width_ok(input int bits);
    return bits == 8 || bits == 16 || bits == 32;
  endfunction
  function automatic logic [1:0] width_enc(input int bits);
    return bits == 32 ? PIPE_WIDTH_32 : bits == 16 ? PIPE_WIDTH_16 : PIPE_WIDTH_8;
  endfunction
  // map holds the width encoding of each generation, entry 0 = Gen1
  function automatic logic [1:0] gen_to_width(input logic [2:0] g, input logic [4:0][1:0] map);
    return map[g - GEN1];
  endfunction
endpackage

// File: rtl/pipe_cycle_timer.sv
// pipe_cycle_timer: loadable 16-bit up-counter with clear and terminal-count compare
module pipe_cycle_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        en_i,
  input  logic [15:0] term_i,
  output logic        tc_o
);
  logic [15:0] cnt_q;
  // clear beats load, load beats count
  always_ff @(posedge clk)
    cnt_q <= (reset || clr_i) ? '0 : load_i ? load_val_i : en_i ? cnt_q + 16'd1 : cnt_q;
  assign tc_o = cnt_q == term_i;
endmodule

// File: rtl/pipe_rate_change_ctrl.sv
// pipe_rate_change_ctrl: quiesces the lane, drives the new PIPE rate/width, waits for PhyStatus, commits gen
module pipe_rate_change_ctrl
  import pipe_pkg::*;
#(
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 16,
  parameter int GEN3_PIPEWIDTH = 32,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8,
  parameter int DRAIN_CYCLES   = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rate_req,
  input  logic [2:0] target_gen,
  input  logic       phy_status,
  output logic [2:0] gen,
  output logic [2:0] pipe_rate,
  output logic [1:0] pipe_width,
  output logic       hold,
  output logic       busy,
  output logic       done,
  output logic       fail
);
  localparam logic [4:0][1:0] WMAP = {width_enc(GEN5_PIPEWIDTH), width_enc(GEN4_PIPEWIDTH),
    width_enc(GEN3_PIPEWIDTH), width_enc(GEN2_PIPEWIDTH), width_enc(GEN1_PIPEWIDTH)};
  localparam logic [15:0] DRAIN_TERM  = 16'(DRAIN_CYCLES - 1);
  localparam logic [15:0] SETTLE_TERM = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] WAIT_TERM   = 16'(TIMEOUT_CYCLES - 1);
  if (!(width_ok(GEN1_PIPEWIDTH) && width_ok(GEN2_PIPEWIDTH) && width_ok(GEN3_PIPEWIDTH) &&
        width_ok(GEN4_PIPEWIDTH) && width_ok(GEN5_PIPEWIDTH))) begin : g_bad_width
    $error("GENx_PIPEWIDTH must be 8, 16 or 32");
  end
  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 255 || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cycles
    $error("cycle parameter out of range");
  end
  state_e      state_q, state_d;
  logic [2:0]  gen_q, gen_d, rate_q, rate_d, tgt_q, tgt_d, old_q, old_d;
  logic [1:0]  width_q, width_d;
  logic        hold_q, hold_d, done_q, done_d, fail_q, fail_d;
  logic        tc, req_ok;
  logic [15:0] term;
  assign req_ok = target_gen >= GEN1 && target_gen <= GEN5;
  assign term = state_q == DRAIN ? DRAIN_TERM : state_q == RATE_WAIT ? WAIT_TERM : SETTLE_TERM;
  pipe_cycle_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (state_d != state_q),
    .load_i     (1'b0),
    .load_val_i (16'd0),
    .en_i       (state_q != IDLE),
    .term_i     (term),
    .tc_o       (tc)
  );
  // state and output registers
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      gen_q   <= GEN1;
      rate_q  <= '0;
      width_q <= WMAP[0];
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      tgt_q   <= GEN1;
      old_q   <= GEN1;
    end else begin
      state_q <= state_d;
      gen_q   <= gen_d;
      rate_q  <= rate_d;
      width_q <= width_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      tgt_q   <= tgt_d;
      old_q   <= old_d;
    end
  // next state: PhyStatus takes priority over the timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (rate_req && req_ok && target_gen != gen_q) state_d = DRAIN;
      DRAIN:     if (tc) state_d = RATE_WAIT;
      RATE_WAIT: state_d = phy_status ? SETTLE : tc ? IDLE : RATE_WAIT;
      SETTLE:    if (tc) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  // register updates: PHY sees the new rate at end of drain, gen commits only on PhyStatus
  always_comb begin
    gen_d   = gen_q;
    rate_d  = rate_q;
    width_d = width_q;
    hold_d  = hold_q;
    tgt_d   = tgt_q;
    old_d   = old_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    case (state_q)
      IDLE: if (rate_req) begin
        fail_d = !req_ok;
        done_d = req_ok && target_gen == gen_q;
        if (state_d == DRAIN) begin
          tgt_d  = target_gen;
          old_d  = gen_q;
          hold_d = 1'b1;
        end
      end
      DRAIN: if (tc) begin
        rate_d  = tgt_q - GEN1;
        width_d = gen_to_width(tgt_q, WMAP);
      end
      RATE_WAIT: if (phy_status) gen_d = tgt_q;
      else if (tc) begin
        rate_d  = old_q - GEN1;
        width_d = gen_to_width(old_q, WMAP);
        hold_d  = 1'b0;
        fail_d  = 1'b1;
      end
      SETTLE: if (tc) begin
        hold_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end
  assign gen        = gen_q;
  assign pipe_rate  = rate_q;
  assign pipe_width = width_q;
  assign hold       = hold_q;
  assign busy       = state_q != IDLE;
  assign done       = done_q;
  assign fail       = fail_q;
endmodule

// File: tb/tb_pipe_rate_change_ctrl.sv
// tb_pipe_rate_change_ctrl: directed plus randomized rate changes checked against a timeline model
module tb_pipe_rate_change_ctrl;
  localparam int D = 4;
  localparam int S = 8;
  localparam int T = 1024;
  logic clk = 1'b0;
  logic reset, rate_req, phy_status;
  logic [2:0] target_gen, gen, pipe_rate;
  logic [1:0] pipe_width;
  logic hold, busy, done, fail;
  logic [11:0] obs;
  int n_cmp = 0;
  int n_bad = 0;
  int mgen;
  pipe_rate_change_ctrl dut (
    .clk(clk), .reset(reset), .rate_req(rate_req), .target_gen(target_gen), .phy_status(phy_status),
    .gen(gen), .pipe_rate(pipe_rate), .pipe_width(pipe_width), .hold(hold), .busy(busy),
    .done(done), .fail(fail)
  );
  always #5 clk = ~clk;
  assign obs = {gen, pipe_rate, pipe_width, hold, busy, done, fail};
  // PIPE width in bits per generation: 8,16,32,8,8 -> encodings 0,1,2,0,0
  function automatic logic [1:0] wenc(input int g);
    int bits;
    bits = (g == 2) ? 16 : (g == 3) ? 32 : 8;
    return bits == 32 ? 2'd2 : bits == 16 ? 2'd1 : 2'd0;
  endfunction
  // rg is the generation whose rate/width is currently presented to the PHY
  function automatic logic [11:0] ev(input int g, input bit h, input bit b, input bit d, input bit f, input int rg);
    return {3'(g), 3'(rg - 1), wenc(rg), h, b, d, f};
  endfunction
  function automatic bit coin();
    return $urandom_range(0, 1) == 1;
  endfunction
  task automatic step(input string tag, input logic [11:0] e);
    @(posedge clk);
    #1;
    n_cmp++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (gen,rate,width,hold,busy,done,fail)", tag, obs, e);
    end
  endtask
  task automatic idle_req(input int t);
    rate_req = 1'b1;
    target_gen = 3'(t);
    phy_status = coin();
    step(t == mgen ? "same_gen" : "bad_gen", ev(mgen, 0, 0, t == mgen, t != mgen, mgen));
    rate_req = 1'b0;
    phy_status = 1'b0;
    step("after_idle_req", ev(mgen, 0, 0, 0, 0, mgen));
  endtask
  // w: wait cycle carrying PhyStatus (0 = none), rst_at: wait cycle with reset (0 = none),
  // req2: drain cycle carrying a second request (0 = none), noise: random ignored inputs
  task automatic change(input int t, input int w, input int rst_at, input int req2, input bit noise);
    rate_req = 1'b1;
    target_gen = 3'(t);
    phy_status = 1'b0;
    step("accept", ev(mgen, 1, 1, 0, 0, mgen));
    for (int i = 1; i <= D; i++) begin
      rate_req = (i == req2);
      target_gen = 3'((i == req2) ? ((t == 5) ? 1 : 5) : t);
      phy_status = noise && coin();
      step("drain", ev(mgen, 1, 1, 0, 0, (i == D) ? t : mgen));
    end
    for (int j = 1; j <= T; j++) begin
      rate_req = noise && coin();
      target_gen = 3'($urandom_range(0, 7));
      phy_status = (j == w);
      if (j == rst_at) begin
        reset = 1'b1;
        step("reset_in_wait", ev(1, 0, 0, 0, 0, 1));
        reset = 1'b0;
        rate_req = 1'b0;
        mgen = 1;
        for (int k = 0; k < 6; k++) begin
          phy_status = (k == 2);
          step("post_reset", ev(1, 0, 0, 0, 0, 1));
        end
        phy_status = 1'b0;
        return;
      end
      if (j == w) begin
        step("phy_commit", ev(t, 1, 1, 0, 0, t));
        break;
      end
      if (j == T) begin
        step("timeout", ev(mgen, 0, 0, 0, 1, mgen));
        rate_req = 1'b0;
        phy_status = 1'b0;
        step("after_timeout", ev(mgen, 0, 0, 0, 0, mgen));
        return;
      end
      step("wait", ev(mgen, 1, 1, 0, 0, t));
    end
    for (int k = 1; k <= S; k++) begin
      rate_req = noise && coin();
      target_gen = 3'($urandom_range(0, 7));
      phy_status = noise && coin();
      step("settle", ev(t, k != S, k != S, k == S, 0, t));
    end
    mgen = t;
    rate_req = 1'b0;
    phy_status = 1'b0;
    step("after_done", ev(t, 0, 0, 0, 0, t));
  endtask
  initial begin
    int r, t, w;
    reset = 1'b1;
    rate_req = 1'b0;
    phy_status = 1'b0;
    target_gen = 3'd0;
    mgen = 1;
    step("reset", ev(1, 0, 0, 0, 0, 1));
    step("reset", ev(1, 0, 0, 0, 0, 1));
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      phy_status = coin();
      step("idle", ev(1, 0, 0, 0, 0, 1));
    end
    phy_status = 1'b0;
    change(2, 0, 0, 0, 0);
    change(3, 10, 0, 0, 1);
    idle_req(3);
    idle_req(6);
    idle_req(0);
    idle_req(7);
    change(1, T, 0, 2, 1);
    change(4, 0, 6, 0, 1);
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2) idle_req((r == 0) ? 0 : $urandom_range(6, 7));
      else if (r == 2) idle_req(mgen);
      else begin
        t = ((mgen - 1 + $urandom_range(1, 4)) % 5) + 1;
        w = (r == 9) ? 0 : (r == 8) ? T : $urandom_range(1, 20);
        change(t, w, 0, $urandom_range(0, D), 1'b1);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
